// File: rtl/dut_seq_pkg.sv
// dut_seq_pkg: shared word indices, bus width and loader state encoding
package dut_seq_pkg;
   localparam int BUS_W         = 128;
   localparam int WIDX_SIG      = 0;
   localparam int WIDX_FF       = 1;
   localparam int WIDX_TEMPLATE = 2;
   localparam int WIDX_CYCLE    = 3;
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL, S_FINISH} state_t;
endpackage

// File: rtl/dut_vector_sequencer_run_timer.sv
// dut_run_timer: run-length down-counter driving the registered perform-test enable
module dut_run_timer (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_clr,
   input  logic       i_load,
   input  logic [7:0] i_len,
   output logic       o_last,
   output logic       o_active,
   output logic       o_perform_test
);
   logic [7:0] r_cnt;
   logic       r_perf;
   logic       w_active;
   assign w_active       = r_cnt != 8'd0;
   assign o_active       = w_active;
   assign o_last         = r_cnt == 8'd1;
   assign o_perform_test = r_perf;
   always_ff @(posedge i_clk)
      if (i_rst || i_clr) begin
         r_cnt  <= 8'd0;
         r_perf <= 1'b0;
      end else begin
         r_cnt  <= i_load ? i_len : r_cnt - {7'd0, w_active};
         r_perf <= w_active;
      end
endmodule

// File: rtl/dut_vector_sequencer.sv
// dut_vector_sequencer: streams vector words into the bank pre-buffers and paces transfers/runs
module dut_vector_sequencer
   import dut_seq_pkg::*;
#(
   parameter int WORDS_PER_VEC = 4,
   parameter int CNT_W         = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [7:0]       i_run_len,
   input  logic             i_vec_valid,
   output logic             o_vec_ready,
   input  logic [BUS_W-1:0] i_vec_data,
   input  logic             i_vec_last,
   output logic [BUS_W-1:0] o_bus128,
   output logic             o_sig_load,
   output logic             o_ff_load,
   output logic             o_template_load,
   output logic             o_cycle_load,
   output logic             o_sig_transfer,
   output logic             o_ff_transfer,
   output logic             o_template_transfer,
   output logic             o_cycle_transfer,
   output logic             o_perform_test,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_underrun,
   output logic [CNT_W-1:0] o_vec_count
);
   state_t           r_state, w_next;
   logic [1:0]       r_widx;
   logic [3:0]       r_load;
   logic [BUS_W-1:0] r_bus;
   logic [7:0]       r_run_len;
   logic [CNT_W-1:0] r_count;
   logic             r_ready, r_pending, r_vlast, r_xfer, r_busy, r_done, r_underrun;
   logic             w_start, w_accept, w_last_word, w_xfer, w_done, w_underrun;
   logic             w_run_last, w_run_active;
   assign w_start     = (r_state == S_IDLE) && i_start && !i_abort;
   assign w_accept    = r_ready && i_vec_valid && !i_abort;
   assign w_last_word = r_widx == 2'(WORDS_PER_VEC - 1);
   // transfer in an idle gap or exactly on the final run cycle keeps runs seamless
   assign w_xfer      = r_pending && (!w_run_active || w_run_last) && !i_abort;
   assign w_done      = (r_state == S_FINISH) && !w_run_active && !i_abort;
   assign w_underrun  = w_run_last && !r_pending && (r_state != S_FINISH) && !i_abort;
   dut_run_timer u_timer (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_clr         (i_abort),
      .i_load        (w_xfer),
      .i_len         (r_run_len),
      .o_last        (w_run_last),
      .o_active      (w_run_active),
      .o_perform_test(o_perform_test)
   );
   always_ff @(posedge i_clk)
      if (i_rst) begin
         r_state <= S_IDLE;
         r_ready <= 1'b0;
      end else begin
         r_state <= w_next;
         r_ready <= w_next == S_LOAD;
      end
   always_comb begin
      w_next = r_state;
      if (i_abort) w_next = S_IDLE;
      else if (w_start) w_next = S_LOAD;
      else if (w_accept && w_last_word) w_next = S_FULL;
      else if (w_xfer) w_next = r_vlast ? S_FINISH : S_LOAD;
      else if (w_done) w_next = S_IDLE;
   end
   always_ff @(posedge i_clk)
      if (i_rst) begin
         r_widx     <= 2'd0;
         r_load     <= 4'd0;
         r_bus      <= '0;
         r_run_len  <= 8'd0;
         r_count    <= '0;
         r_pending  <= 1'b0;
         r_vlast    <= 1'b0;
         r_xfer     <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_load <= w_accept ? 4'd1 << r_widx : 4'd0;
         r_xfer <= w_xfer;
         r_done <= w_done;
         if (w_accept) begin
            r_bus  <= i_vec_data;
            r_widx <= r_widx + 2'd1;
         end
         if (w_accept && w_last_word) begin
            r_pending <= 1'b1;
            r_vlast   <= i_vec_last;
         end
         if (w_xfer) begin
            r_pending <= 1'b0;
            r_count   <= r_count + CNT_W'(1);
         end
         if (w_underrun) r_underrun <= 1'b1;
         if (w_start) begin
            r_busy     <= 1'b1;
            r_underrun <= 1'b0;
            r_count    <= '0;
            r_widx     <= 2'd0;
            r_run_len  <= (i_run_len == 8'd0) ? 8'd1 : i_run_len;
         end
         if (i_abort) begin
            r_busy    <= 1'b0;
            r_pending <= 1'b0;
         end
         if (w_done) r_busy <= 1'b0;
      end
   assign o_vec_ready         = r_ready;
   assign o_bus128            = r_bus;
   assign o_sig_load          = r_load[WIDX_SIG];
   assign o_ff_load           = r_load[WIDX_FF];
   assign o_template_load     = r_load[WIDX_TEMPLATE];
   assign o_cycle_load        = r_load[WIDX_CYCLE];
   assign o_sig_transfer      = r_xfer;
   assign o_ff_transfer       = r_xfer;
   assign o_template_transfer = r_xfer;
   assign o_cycle_transfer    = r_xfer;
   assign o_busy              = r_busy;
   assign o_done              = r_done;
   assign o_underrun          = r_underrun;
   assign o_vec_count         = r_count;
endmodule
